approx_add_err_sweep: RTL and testbench

Exhaustive characterisation engine for approximate unsigned adders. It drives every operand pair into a combinational W-bit approximate adder placed next to it, and consumes the adder's (W+1)-bit sum. It compares that sum against an internally computed exact sum and accumulates error statistics: error count (EP), sum of absolute error (MAE numerator), worst-case error with its first operand pair (WCE), and sum of squared error (MSE numerator). It sits directly downstream of the adder under test and is the hardware front end for generating its error figures and LUT entries.

---
 rtl/approx_add_err_sweep.sv | 122 ++++++++++++
 tb/tb_approx_add_err_sweep.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_err_sweep.sv
// Exhaustive error characterisation of a combinational W-bit approximate adder:
// walks every operand pair, compares against the exact sum, accumulates EP/MAE/WCE/MSE figures.
module approx_add_err_sweep #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [W:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     err_count,
  output logic [3*W:0]     sum_abs_err,
  output logic [W:0]       max_abs_err,
  output logic [W-1:0]     wce_a,
  output logic [W-1:0]     wce_b,
  output logic [4*W+1:0]   sum_sq_err
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [2*W-1:0]   idx;
  logic             last_pair;
  logic             accept;

  logic [W:0]       exact;
  logic signed [W+1:0] diff;
  logic [W:0]       abs_diff;

  logic             cap_valid;
  logic [W:0]       cap_abs;
  logic [W-1:0]     cap_a;
  logic [W-1:0]     cap_b;
  logic [2*W+1:0]   cap_sq;

  assign last_pair = (idx == '1);
  assign accept    = (state == IDLE) && start;

  // op_b is the low half of the index, so it is the inner loop
  assign op_a = idx[2*W-1:W];
  assign op_b = idx[W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP:   if (last_pair) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SWEEP, DRAIN: busy = 1'b1;
      DONE:         done = 1'b1;
      default:      ;
    endcase
  end

  // Index holds at the last pair after the sweep; only reset or a new start clears it
  always_ff @(posedge clk) begin
    if (!rst_n)                         idx <= '0;
    else if (accept)                    idx <= '0;
    else if (state == SWEEP && !last_pair) idx <= idx + 1'b1;
  end

  always_comb begin
    exact    = {1'b0, op_a} + {1'b0, op_b};
    diff     = signed'({1'b0, approx_sum}) - signed'({1'b0, exact});
    abs_diff = diff[W+1] ? (W+1)'(-diff) : diff[W:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_abs   <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
    end else begin
      cap_valid <= (state == SWEEP);
      cap_abs   <= abs_diff;
      cap_a     <= op_a;
      cap_b     <= op_b;
    end
  end

  assign cap_sq = (2*W+2)'(cap_abs) * (2*W+2)'(cap_abs);

  // Strict compare keeps the earliest pair on ties
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
      max_abs_err <= '0;
      wce_a       <= '0;
      wce_b       <= '0;
    end else if (cap_valid) begin
      err_count   <= err_count + (2*W+1)'(cap_abs != '0);
      sum_abs_err <= sum_abs_err + (3*W+1)'(cap_abs);
      sum_sq_err  <= sum_sq_err + (4*W+2)'(cap_sq);
      if (cap_abs > max_abs_err) begin
        max_abs_err <= cap_abs;
        wce_a       <= cap_a;
        wce_b       <= cap_b;
      end
    end
  end

endmodule

// File: tb/tb_approx_add_err_sweep.sv
// Scoreboard bench: three W=8 engines (exact, LSB-zero, zero stubs) share one sweep;
// a W=4 engine with a selectable stub covers reset abort and held start.
module tb_approx_add_err_sweep;

  typedef struct {
    longint ec, sae, mx, wa, wb, sse, e0, lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$], q1[$], q2[$], q4[$];

  // ---------------- W=8 group ----------------
  logic rst8_n, start8;
  logic [7:0]  a_x, b_x, a_l, b_l, a_z, b_z;
  logic [8:0]  ap_x, ap_l, ap_z;
  logic        busy_x, busy_l, busy_z, done_x, done_l, done_z;
  logic [16:0] ec_x, ec_l, ec_z;
  logic [24:0] sae_x, sae_l, sae_z;
  logic [8:0]  mx_x, mx_l, mx_z;
  logic [7:0]  wa_x, wb_x, wa_l, wb_l, wa_z, wb_z;
  logic [33:0] sse_x, sse_l, sse_z;

  assign ap_x = {1'b0, a_x} + {1'b0, b_x};
  assign ap_l = ({1'b0, a_l} + {1'b0, b_l}) & 9'h1FE;
  assign ap_z = '0;

  approx_add_err_sweep #(.W(8)) dut_x (
    .clk(clk), .rst_n(rst8_n), .start(start8), .op_a(a_x), .op_b(b_x),
    .approx_sum(ap_x), .busy(busy_x), .done(done_x), .err_count(ec_x),
    .sum_abs_err(sae_x), .max_abs_err(mx_x), .wce_a(wa_x), .wce_b(wb_x),
    .sum_sq_err(sse_x));

  approx_add_err_sweep #(.W(8)) dut_l (
    .clk(clk), .rst_n(rst8_n), .start(start8), .op_a(a_l), .op_b(b_l),
    .approx_sum(ap_l), .busy(busy_l), .done(done_l), .err_count(ec_l),
    .sum_abs_err(sae_l), .max_abs_err(mx_l), .wce_a(wa_l), .wce_b(wb_l),
    .sum_sq_err(sse_l));

  approx_add_err_sweep #(.W(8)) dut_z (
    .clk(clk), .rst_n(rst8_n), .start(start8), .op_a(a_z), .op_b(b_z),
    .approx_sum(ap_z), .busy(busy_z), .done(done_z), .err_count(ec_z),
    .sum_abs_err(sae_z), .max_abs_err(mx_z), .wce_a(wa_z), .wce_b(wb_z),
    .sum_sq_err(sse_z));

  // ---------------- W=4 engine ----------------
  logic rst4_n, start4;
  int   m4;
  logic [3:0]  a4, b4, wa4, wb4;
  logic [4:0]  ap4, mx4;
  logic        busy4, done4;
  logic [8:0]  ec4;
  logic [12:0] sae4;
  logic [17:0] sse4;

  always_comb begin
    ap4 = '0;
    case (m4)
      0:       ap4 = {1'b0, a4} + {1'b0, b4};
      1:       ap4 = ({1'b0, a4} + {1'b0, b4}) & 5'h1E;
      default: ap4 = '0;
    endcase
  end

  approx_add_err_sweep #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .op_a(a4), .op_b(b4),
    .approx_sum(ap4), .busy(busy4), .done(done4), .err_count(ec4),
    .sum_abs_err(sae4), .max_abs_err(mx4), .wce_a(wa4), .wce_b(wb4),
    .sum_sq_err(sse4));

  // ---------------- checking ----------------
  task automatic chk(string tag, longint obs, longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference statistics computed by brute force over all pairs
  function automatic exp_t model(int w, int mode, longint e0);
    exp_t   r;
    longint n, ex, ap, ad;
    r = '{default: 0};
    n = longint'(1) << w;
    for (longint a = 0; a < n; a++) begin
      for (longint b = 0; b < n; b++) begin
        ex = a + b;
        case (mode)
          0:       ap = ex;
          1:       ap = (ex / 2) * 2;
          default: ap = 0;
        endcase
        ad = (ap >= ex) ? ap - ex : ex - ap;
        if (ad != 0) r.ec++;
        r.sae += ad;
        r.sse += ad * ad;
        if (ad > r.mx) begin
          r.mx = ad;
          r.wa = a;
          r.wb = b;
        end
      end
    end
    r.e0  = e0;
    r.lat = n * n + 1;
    return r;
  endfunction

  task automatic score(string nm, exp_t e, longint ec, longint sae, longint mx,
                       longint wa, longint wb, longint sse, longint oa, longint ob,
                       longint bz, int w);
    chk({nm, "_latency"}, longint'(cyc) - e.e0, e.lat);
    chk({nm, "_err_count"}, ec, e.ec);
    chk({nm, "_sum_abs_err"}, sae, e.sae);
    chk({nm, "_max_abs_err"}, mx, e.mx);
    chk({nm, "_wce_a"}, wa, e.wa);
    chk({nm, "_wce_b"}, wb, e.wb);
    chk({nm, "_sum_sq_err"}, sse, e.sse);
    chk({nm, "_busy_at_done"}, bz, 0);
    chk({nm, "_op_a_hold"}, oa, (longint'(1) << w) - 1);
    chk({nm, "_op_b_hold"}, ob, (longint'(1) << w) - 1);
  endtask

  always @(negedge clk) begin : mon_x
    exp_t e;
    if (done_x) begin
      if (q0.size() == 0) chk("x8_spurious_done", done_x, 0);
      else begin
        e = q0.pop_front();
        score("x8", e, ec_x, sae_x, mx_x, wa_x, wb_x, sse_x, a_x, b_x, busy_x, 8);
      end
    end
  end

  always @(negedge clk) begin : mon_l
    exp_t e;
    if (done_l) begin
      if (q1.size() == 0) chk("l8_spurious_done", done_l, 0);
      else begin
        e = q1.pop_front();
        score("l8", e, ec_l, sae_l, mx_l, wa_l, wb_l, sse_l, a_l, b_l, busy_l, 8);
      end
    end
  end

  always @(negedge clk) begin : mon_z
    exp_t e;
    if (done_z) begin
      if (q2.size() == 0) chk("z8_spurious_done", done_z, 0);
      else begin
        e = q2.pop_front();
        score("z8", e, ec_z, sae_z, mx_z, wa_z, wb_z, sse_z, a_z, b_z, busy_z, 8);
      end
    end
  end

  always @(negedge clk) begin : mon_4
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) chk("w4_spurious_done", done4, 0);
      else begin
        e = q4.pop_front();
        score("w4", e, ec4, sae4, mx4, wa4, wb4, sse4, a4, b4, busy4, 4);
      end
    end
  end

  task automatic check_zero4(string tag);
    chk({tag, "_op_a"}, a4, 0);
    chk({tag, "_op_b"}, b4, 0);
    chk({tag, "_busy"}, busy4, 0);
    chk({tag, "_done"}, done4, 0);
    chk({tag, "_err_count"}, ec4, 0);
    chk({tag, "_sum_abs_err"}, sae4, 0);
    chk({tag, "_max_abs_err"}, mx4, 0);
    chk({tag, "_wce_a"}, wa4, 0);
    chk({tag, "_wce_b"}, wb4, 0);
    chk({tag, "_sum_sq_err"}, sse4, 0);
  endtask

  task automatic wait_drain(string tag, int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (q0.size() + q1.size() + q2.size() + q4.size() == 0 &&
          !busy4 && !busy_x && !busy_l && !busy_z) break;
      @(negedge clk);
    end
    chk({tag, "_pending_results"}, q0.size() + q1.size() + q2.size() + q4.size(), 0);
  endtask

  task automatic run4(string tag, int mode);
    m4 = mode;
    @(negedge clk);
    start4 = 1'b1;
    q4.push_back(model(4, mode, longint'(cyc) + 1));
    @(negedge clk);
    start4 = 1'b0;
    chk({tag, "_busy_after_start"}, busy4, 1);
    chk({tag, "_first_pair"}, {a4, b4}, 0);
    wait_drain(tag, 400);
  endtask

  initial begin
    longint e0;
    int     k;
    rst4_n = 1'b0; rst8_n = 1'b0; start4 = 1'b0; start8 = 1'b0; m4 = 2;
    repeat (2) @(negedge clk);
    rst4_n = 1'b1; rst8_n = 1'b1;
    check_zero4("reset");
    chk("reset_busy8", busy_l, 0);
    chk("reset_sse8", sse_z, 0);

    // W=4 constant-zero stub
    run4("w4_zero", 2);

    // Abort mid-sweep with the LSB-zero stub, then a clean run
    m4 = 1;
    @(negedge clk);
    start4 = 1'b1;
    q4.push_back(model(4, 1, longint'(cyc) + 1));
    @(negedge clk);
    start4 = 1'b0;
    for (k = 0; k < 300 && {a4, b4} != 8'd100; k++) @(negedge clk);
    chk("abort_reached_i100", {a4, b4}, 100);
    rst4_n = 1'b0;
    @(negedge clk);
    rst4_n = 1'b1;
    void'(q4.pop_back());
    check_zero4("abort");
    repeat (300) @(negedge clk);
    chk("abort_stays_idle", busy4, 0);
    run4("w4_after_abort", 1);

    // start held high: second sweep accepted in the IDLE cycle after DONE
    m4 = 1;
    @(negedge clk);
    start4 = 1'b1;
    e0 = longint'(cyc) + 1;
    q4.push_back(model(4, 1, e0));
    q4.push_back(model(4, 1, e0 + 259));
    while (longint'(cyc) < e0 + 264) @(negedge clk);
    chk("held_second_sweep_busy", busy4, 1);
    start4 = 1'b0;
    wait_drain("w4_held", 600);

    // One shared W=8 sweep for all three stubs
    @(negedge clk);
    start8 = 1'b1;
    e0 = longint'(cyc) + 1;
    q0.push_back(model(8, 0, e0));
    q1.push_back(model(8, 1, e0));
    q2.push_back(model(8, 2, e0));
    @(negedge clk);
    start8 = 1'b0;
    chk("w8_busy_after_start", busy_x, 1);
    chk("w8_first_pair", {a_l, b_l}, 0);
    wait_drain("w8", 70000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
